multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Multicycle control unit for the processor datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the immediate extender's type select, ALU operand and op selects, register-file and memory enables. Waits on a single shared memory port through a req/ready handshake and stops in HALT on the halt opcode.

Parameters:
OPW, 5, opcode width; opcode is Instr[31:27] (the extender receives Instr[26:0]).
OP_HALT, 5'b11111, halt opcode.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
Instr  in  32  instruction register contents (valid from DECODE on)
Zero  in  1  ALU zero flag (sampled in EXEC)
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
MemWrite  out  1  store when mem_req=1
AdrSrc  out  1  0=PC address, 1=ALU result address
IRWrite  out  1  load instruction register
PCWrite  out  1  update PC
PCSrc  out  1  0=PC+4, 1=branch/jump target
immediatetype  out  2  extender select: 00 ALU-imm, 01 load/store offset, 10 branch, 11 jump
ALUSrcB  out  1  0=register, 1=extended immediate
ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
RegWrite  out  1  register-file write
ResultSrc  out  1  0=ALU result, 1=memory read data
halted  out  1  high while in HALT

Behaviour:
- Reset (rst_n=0 at a clk edge): state=FETCH. All outputs are 0 except immediatetype=00 and ALUOp=00. Reset is honoured in every state, including mid-memory-wait and HALT.
- Opcode classes on Instr[31:27]:
  - 00xxx: R-type ALU.
  - 01xxx: ALU-immediate.
  - 10000: LOAD.
  - 10001: STORE.
  - 10010: BEQ.
  - 10011: JUMP.
  - OP_HALT: halt.
  - Any other opcode is a NOP and returns to FETCH after DECODE.
- States and transitions:
  - FETCH: mem_req=1, AdrSrc=0. When mem_ready=1, assert IRWrite=1 and PCWrite=1 (PCSrc=0) in that same cycle, then go to DECODE. Otherwise stay, holding mem_req.
  - DECODE: immediatetype set per class, 1 cycle. Next state: ALU/ALUI -> EXEC; LOAD/STORE -> MEMADR; BEQ -> BRANCH; JUMP -> JUMP; HALT -> HALT; other -> FETCH.
  - EXEC: ALUSrcB=0 (R) or 1 (I), ALUOp=10. Next ALUWB.
  - ALUWB: RegWrite=1, ResultSrc=0. Next FETCH.
  - MEMADR: immediatetype=01, ALUSrcB=1, ALUOp=00. Next MEMRD (LOAD) or MEMWR (STORE).
  - MEMRD: mem_req=1, AdrSrc=1, MemWrite=0. Wait for mem_ready, then go to MEMWB.
  - MEMWB: RegWrite=1, ResultSrc=1. Next FETCH.
  - MEMWR: mem_req=1, AdrSrc=1, MemWrite=1. When mem_ready=1, go to FETCH.
  - BRANCH: immediatetype=10, ALUOp=01, ALUSrcB=0. PCWrite=Zero, PCSrc=1. Next FETCH.
  - JUMP: immediatetype=11, PCWrite=1, PCSrc=1. Next FETCH.
  - HALT: halted=1, all enables 0. Stays until reset.
- mem_req is held high and stable with AdrSrc/MemWrite until the cycle where mem_ready=1. No wait-cycle limit. mem_ready is ignored when mem_req=0.
- mem_ready=1 on the first cycle of FETCH/MEMRD/MEMWR completes in that cycle (zero wait).
- Write strobes (IRWrite, PCWrite, RegWrite) are single-cycle pulses. immediatetype holds its class value from DECODE through the instruction's last state.
- Outputs are a Moore function of state, except FETCH's IRWrite/PCWrite (gated by mem_ready) and BRANCH's PCWrite (gated by Zero).

Test Plan:
1. rst_n=0 for 2 clk, then 1, mem_ready=1, Instr=32'h0000_0000 (R-type) -> states FETCH, DECODE, EXEC, ALUWB, FETCH. RegWrite pulses once, in cycle 4. immediatetype stays 00 throughout.
2. Instr opcode 10000 (LOAD), mem_ready low 3 cycles in MEMRD -> mem_req/AdrSrc=1 held 4 cycles, then MEMWB with RegWrite=1 and ResultSrc=1. immediatetype=01 from DECODE on.
3. BEQ with Zero=1 -> BRANCH gives PCWrite=1, PCSrc=1, immediatetype=10. Repeat with Zero=0 -> PCWrite=0, return to FETCH.
4. JUMP opcode 10011 -> immediatetype=11, one PCWrite pulse with PCSrc=1. STORE 10001 -> MEMWR with MemWrite=1, no RegWrite.
5. Opcode 11111 -> halted=1 from the cycle after DECODE. mem_req=0 for 20 cycles. Then rst_n=0 -> FETCH, halted=0.
6. rst_n=0 asserted mid-MEMRD wait -> next edge: state FETCH, mem_req=0 and all strobes 0, before a new mem_req is issued.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and the shared memory handshake.
module multicycle_control_fsm #(
    parameter int unsigned    OPW     = 5,
    parameter logic [OPW-1:0] OP_HALT = OPW'(5'b11111)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic [1:0]  immediatetype,
    output logic        ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        RegWrite,
    output logic        ResultSrc,
    output logic        halted
);

    localparam logic [OPW-1:0] OP_LOAD  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_STORE = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_JUMP  = OPW'(5'b10011);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD,
        S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_ALUI, CL_LOAD, CL_STORE, CL_BEQ, CL_JUMP, CL_HALT, CL_NOP
    } cls_t;

    state_t         state;
    cls_t           cls;
    cls_t           dec_cls;
    logic [OPW-1:0] opcode;
    logic           unused_instr;

    // The extender consumes the low instruction bits; only the opcode is decoded here.
    assign opcode       = Instr[31 -: OPW];
    assign unused_instr = ^Instr[31-OPW:0];

    // Extender type select for an instruction class.
    function automatic logic [1:0] imm_of(input cls_t c);
        case (c)
            CL_LOAD, CL_STORE: imm_of = 2'b01;
            CL_BEQ:            imm_of = 2'b10;
            CL_JUMP:           imm_of = 2'b11;
            default:           imm_of = 2'b00;
        endcase
    endfunction

    // Opcode classification of the current instruction register.
    always_comb begin
        dec_cls = CL_NOP;
        if (opcode == OP_HALT) begin
            dec_cls = CL_HALT;
        end else if (opcode[OPW-1 -: 2] == 2'b00) begin
            dec_cls = CL_ALU;
        end else if (opcode[OPW-1 -: 2] == 2'b01) begin
            dec_cls = CL_ALUI;
        end else begin
            case (opcode)
                OP_LOAD:  dec_cls = CL_LOAD;
                OP_STORE: dec_cls = CL_STORE;
                OP_BEQ:   dec_cls = CL_BEQ;
                OP_JUMP:  dec_cls = CL_JUMP;
                default:  dec_cls = CL_NOP;
            endcase
        end
    end

    // State sequencing; the class is captured in DECODE and held for the instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cls   <= CL_NOP;
        end else begin
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    cls <= dec_cls;
                    case (dec_cls)
                        CL_ALU, CL_ALUI:   state <= S_EXEC;
                        CL_LOAD, CL_STORE: state <= S_MEMADR;
                        CL_BEQ:            state <= S_BRANCH;
                        CL_JUMP:           state <= S_JUMP;
                        CL_HALT:           state <= S_HALT;
                        default:           state <= S_FETCH;
                    endcase
                end
                S_EXEC:   state <= S_ALUWB;
                S_ALUWB:  state <= S_FETCH;
                S_MEMADR: state <= (cls == CL_STORE) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR:  if (mem_ready) state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                S_JUMP:   state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        PCSrc         = 1'b0;
        immediatetype = 2'b00;
        ALUSrcB       = 1'b0;
        ALUOp         = 2'b00;
        RegWrite      = 1'b0;
        ResultSrc     = 1'b0;
        halted        = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: immediatetype = imm_of(dec_cls);
                S_EXEC: begin
                    immediatetype = imm_of(cls);
                    ALUSrcB       = (cls == CL_ALUI);
                    ALUOp         = 2'b10;
                end
                S_ALUWB: begin
                    immediatetype = imm_of(cls);
                    RegWrite      = 1'b1;
                end
                S_MEMADR: begin
                    immediatetype = 2'b01;
                    ALUSrcB       = 1'b1;
                end
                S_MEMRD: begin
                    immediatetype = imm_of(cls);
                    mem_req       = 1'b1;
                    AdrSrc        = 1'b1;
                end
                S_MEMWB: begin
                    immediatetype = imm_of(cls);
                    RegWrite      = 1'b1;
                    ResultSrc     = 1'b1;
                end
                S_MEMWR: begin
                    immediatetype = imm_of(cls);
                    mem_req       = 1'b1;
                    AdrSrc        = 1'b1;
                    MemWrite      = 1'b1;
                end
                S_BRANCH: begin
                    immediatetype = 2'b10;
                    ALUOp         = 2'b01;
                    PCWrite       = Zero;
                    PCSrc         = 1'b1;
                end
                S_JUMP: begin
                    immediatetype = 2'b11;
                    PCWrite       = 1'b1;
                    PCSrc         = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle output vectors predicted from
// instruction class, memory wait lengths and the Zero flag.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instr;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc;
    logic [1:0]  immediatetype, ALUOp;
    logic        ALUSrcB, RegWrite, ResultSrc, halted;
    logic [13:0] outv;

    int total = 0;
    int bad   = 0;

    localparam int C_ALU = 0, C_ALUI = 1, C_LOAD = 2, C_STORE = 3,
                   C_BEQ = 4, C_JUMP = 5, C_HALT = 6, C_NOP = 7;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .immediatetype(immediatetype),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .halted(halted)
    );

    always #5 clk = ~clk;

    assign outv = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, immediatetype,
                   ALUSrcB, ALUOp, RegWrite, ResultSrc, halted};

    // Expected output vector from named fields.
    function automatic logic [13:0] ev(input logic req, input logic we, input logic adr,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic [1:0] imm, input logic srcb,
                                       input logic [1:0] op, input logic rw,
                                       input logic rs, input logic hlt);
        return {req, we, adr, irw, pcw, pcs, imm, srcb, op, rw, rs, hlt};
    endfunction

    function automatic int classify(input logic [31:0] ins);
        int op;
        op = int'(ins[31:27]);
        if (op == 31) return C_HALT;
        if (op < 8)   return C_ALU;
        if (op < 16)  return C_ALUI;
        if (op == 16) return C_LOAD;
        if (op == 17) return C_STORE;
        if (op == 18) return C_BEQ;
        if (op == 19) return C_JUMP;
        return C_NOP;
    endfunction

    function automatic logic [1:0] imm_for(input int c);
        if (c == C_LOAD || c == C_STORE) return 2'b01;
        if (c == C_BEQ)  return 2'b10;
        if (c == C_JUMP) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    // One cycle: starts at a negedge, drives inputs, checks, advances to the next negedge.
    task automatic step(input logic mr, input logic z, input logic [13:0] exp, input string tag);
        mem_ready = mr;
        Zero      = z;
        #1;
        total++;
        assert (outv === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, outv, exp);
        end
        @(negedge clk);
    endtask

    // Hold reset for n cycles, checking that all outputs stay low.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) step(rbit(), rbit(), 14'd0, "reset");
        rst_n = 1'b1;
    endtask

    task automatic fetch_phase(input int fw);
        for (int i = 0; i <= fw; i++) begin
            logic r;
            r = (i == fw);
            step(r, rbit(), ev(1, 0, 0, r, r, 0, 2'b00, 0, 2'b00, 0, 0, 0), "fetch");
        end
    endtask

    // Full instruction: fw/mw are memory wait cycles, z is the ALU zero flag in BRANCH.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z);
        int         c;
        logic [1:0] im;
        c  = classify(ins);
        im = imm_for(c);
        Instr = ins;
        fetch_phase(fw);
        step(rbit(), rbit(), ev(0, 0, 0, 0, 0, 0, im, 0, 2'b00, 0, 0, 0), "decode");
        case (c)
            C_ALU, C_ALUI: begin
                step(rbit(), rbit(), ev(0, 0, 0, 0, 0, 0, im, (c == C_ALUI), 2'b10, 0, 0, 0), "exec");
                step(rbit(), rbit(), ev(0, 0, 0, 0, 0, 0, im, 0, 2'b00, 1, 0, 0), "aluwb");
            end
            C_LOAD, C_STORE: begin
                logic st;
                st = (c == C_STORE);
                step(rbit(), rbit(), ev(0, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 0, 0, 0), "memadr");
                for (int i = 0; i <= mw; i++)
                    step((i == mw), rbit(), ev(1, st, 1, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0),
                         st ? "memwr" : "memrd");
                if (!st)
                    step(rbit(), rbit(), ev(0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 1, 1, 0), "memwb");
            end
            C_BEQ:
                step(rbit(), z, ev(0, 0, 0, 0, z, 1, 2'b10, 0, 2'b01, 0, 0, 0), "branch");
            C_JUMP:
                step(rbit(), rbit(), ev(0, 0, 0, 0, 1, 1, 2'b11, 0, 2'b00, 0, 0, 0), "jump");
            C_HALT:
                for (int i = 0; i < 20; i++)
                    step(rbit(), rbit(), ev(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1), "halt");
            default: ;
        endcase
    endtask

    initial begin
        rst_n     = 1'b0;
        Instr     = 32'h0;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);

        // Reset, then an R-type instruction with zero-wait fetch
        do_reset(2);
        run_instr(32'h0000_0000, 0, 0, 1'b0);

        // LOAD with three wait cycles in MEMRD
        run_instr({5'b10000, 27'h123_4567}, 1, 3, 1'b0);

        // BEQ taken and not taken, JUMP, STORE, ALU-immediate, NOP opcode
        run_instr({5'b10010, 27'h0}, 0, 0, 1'b1);
        run_instr({5'b10010, 27'h0}, 0, 0, 1'b0);
        run_instr({5'b10011, 27'h7ff_ffff}, 2, 0, 1'b0);
        run_instr({5'b10001, 27'h55}, 0, 2, 1'b0);
        run_instr({5'b01101, 27'h1}, 0, 0, 1'b0);
        run_instr({5'b10100, 27'h0}, 0, 0, 1'b0);
        run_instr({5'b11110, 27'h0}, 1, 0, 1'b0);

        // Randomized instruction stream, halt excluded
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if (ins[31:27] == 5'b11111) ins[31:27] = 5'b10000;
            run_instr(ins, int'($urandom_range(3, 0)), int'($urandom_range(4, 0)), rbit());
        end

        // Reset during a MEMRD wait
        Instr = {5'b10000, 27'h0};
        fetch_phase(0);
        step(rbit(), rbit(), ev(0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0), "decode_abort");
        step(rbit(), rbit(), ev(0, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 0, 0, 0), "memadr_abort");
        step(1'b0, rbit(), ev(1, 0, 1, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0), "memrd_wait");
        step(1'b0, rbit(), ev(1, 0, 1, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0), "memrd_wait");
        do_reset(2);
        run_instr({5'b00011, 27'h0}, 2, 0, 1'b0);

        // HALT holds until reset, then normal operation resumes
        run_instr({5'b11111, 27'h0}, 0, 0, 1'b0);
        do_reset(1);
        run_instr({5'b10001, 27'h0}, 0, 1, 1'b0);
        run_instr({5'b10010, 27'h0}, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
